alu_dispatch: RTL and testbench

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_dispatch.sv | 139 +++++++++++++
 tb/tb_alu_dispatch.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// Request dispatcher for a fixed-latency external ALU: registers operands onto the ALU
// ports, tracks each op through a latency pipe, and returns results through an in-order FWFT FIFO.
module alu_dispatch #(
  parameter int WIDTH   = 128,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_opcode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [4:0]       req_shift,
  input  logic [3:0]       req_tag,

  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [4:0]       alu_shiftValue,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  input  logic             alu_sign,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [3:0]       rsp_tag,
  output logic             rsp_err
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int STAGES  = LATENCY + 1;
  localparam int ENTRY_W = WIDTH + 9;

  // Handshakes: a transfer happens at a posedge where valid and ready are both 1.
  // req_ready depends only on the registered outstanding count; rsp_valid only on FIFO occupancy.
  logic [CNT_W-1:0] outstanding;
  logic             fire;
  logic             pop;

  assign req_ready = (outstanding < CNT_W'(DEPTH));
  assign fire      = req_valid & req_ready;
  assign pop       = rsp_valid & rsp_ready;

  // Outstanding spans the whole lifetime of an op (in the ALU pipe or queued), so the
  // FIFO can never be written while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({fire, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode     <= '0;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
    end else if (fire) begin
      alu_opcode     <= req_opcode;
      alu_input1     <= req_a;
      alu_input2     <= req_b;
      alu_shiftValue <= req_shift;
    end
  end

  logic [STAGES-1:0]      sr_valid;
  logic [STAGES-1:0]      sr_err;
  logic [STAGES-1:0][3:0] sr_tag;

  // Stage k holds the op fired k edges ago; the last stage lines up with a valid alu_result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_valid <= '0;
      sr_err   <= '0;
      sr_tag   <= '0;
    end else begin
      sr_valid[0] <= fire;
      sr_err[0]   <= (req_opcode >= 4'd7);
      sr_tag[0]   <= req_tag;
      for (int i = 1; i < STAGES; i++) begin
        sr_valid[i] <= sr_valid[i-1];
        sr_err[i]   <= sr_err[i-1];
        sr_tag[i]   <= sr_tag[i-1];
      end
    end
  end

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               wr;

  assign wr = sr_valid[LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= {alu_result, alu_carry, alu_zero, alu_ovf, alu_sign,
                        sr_tag[LATENCY], sr_err[LATENCY]};
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // First-word-fall-through: the head entry is always on the response payload.
  assign rsp_valid = (fifo_cnt != '0);
  assign {rsp_result, rsp_flags, rsp_tag, rsp_err} = mem[rd_ptr];

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a two-stage pipelined ALU model on the alu_* ports.
module tb_alu_dispatch;
  localparam int WIDTH   = 128;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_opcode;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [4:0]       req_shift;
  logic [3:0]       req_tag;
  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_input1;
  logic [WIDTH-1:0] alu_input2;
  logic [4:0]       alu_shiftValue;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_zero;
  logic             alu_ovf;
  logic             alu_sign;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic [3:0]       rsp_tag;
  logic             rsp_err;

  int checks = 0;
  int errors = 0;
  logic [WIDTH+4:0] exp_q[$];

  alu_dispatch #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_shift(req_shift), .req_tag(req_tag),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shiftValue(alu_shiftValue), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_sign(alu_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  // ALU model: result = {value, carry, zero, ovf, sign}, two edges after the operand ports change
  function automatic logic [WIDTH+3:0] alu_fn(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b, input logic [4:0] sh);
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             o;
    wide = '0;
    r = '0;
    c = 1'b0;
    o = 1'b0;
    case (op)
      4'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[WIDTH-1:0];
        c = wide[WIDTH];
        o = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        wide = {1'b0, a} - {1'b0, b};
        r = wide[WIDTH-1:0];
        c = wide[WIDTH];
        o = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      default: r = '0;
    endcase
    return {r, c, (r == '0), o, r[WIDTH-1]};
  endfunction

  logic [WIDTH+3:0] alu_p1;
  logic [WIDTH+3:0] alu_p2;

  always_ff @(posedge clk) begin
    alu_p1 <= alu_fn(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
    alu_p2 <= alu_p1;
  end

  assign {alu_result, alu_carry, alu_zero, alu_ovf, alu_sign} = alu_p2;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [4:0] sh, input logic [3:0] tag);
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    req_shift  = sh;
    req_tag    = tag;
  endtask

  // scoreboard: compare the head response against the oldest expectation (pop happens at the next edge)
  task automatic score_head(input string tag);
    logic [WIDTH+4:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, WIDTH'(rsp_tag), WIDTH'(5'h1f));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_tag"}, WIDTH'(rsp_tag), WIDTH'(e[WIDTH+3:WIDTH]));
      check({tag, "_result"}, rsp_result, e[WIDTH-1:0]);
      check({tag, "_err"}, WIDTH'(rsp_err), WIDTH'(e[WIDTH+4]));
    end
  endtask

  task automatic drain(input int n);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    rsp_ready = 1'b1;
    while (got < n && cyc < 100) begin
      if (rsp_valid) begin
        score_head("drain");
        got++;
      end
      tick();
      cyc++;
    end
    rsp_ready = 1'b0;
    check("drain_count", WIDTH'(got), WIDTH'(n));
  endtask

  initial begin
    int   k;
    int   got;
    int   cyc;
    bit   stall;
    bit   any_valid;
    int   nxt;

    rst = 1'b1;
    req_valid = 1'b0;
    req_opcode = '0;
    req_a = '0;
    req_b = '0;
    req_shift = '0;
    req_tag = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();

    check("rst_req_ready", WIDTH'(req_ready), WIDTH'(1));
    check("rst_rsp_valid", WIDTH'(rsp_valid), WIDTH'(0));
    check("rst_outstanding", WIDTH'(dut.outstanding), WIDTH'(0));
    check("rst_alu_opcode", WIDTH'(alu_opcode), WIDTH'(0));
    check("rst_alu_input1", alu_input1, WIDTH'(0));
    check("rst_rsp_result", rsp_result, WIDTH'(0));
    check("rst_rsp_tag", WIDTH'(rsp_tag), WIDTH'(0));

    // single ADD fired at the first edge after reset release: 5 + 7 = 12
    rst = 1'b0;
    set_req(4'd0, WIDTH'(5), WIDTH'(7), 5'd0, 4'd3);
    tick();
    req_valid = 1'b0;
    check("add_alu_input1", alu_input1, WIDTH'(5));
    check("add_alu_input2", alu_input2, WIDTH'(7));
    check("add_outstanding", WIDTH'(dut.outstanding), WIDTH'(1));
    tick();
    check("add_valid_e1", WIDTH'(rsp_valid), WIDTH'(0));
    tick();
    check("add_valid_e2", WIDTH'(rsp_valid), WIDTH'(0));
    tick();
    check("add_valid_e3", WIDTH'(rsp_valid), WIDTH'(1));
    check("add_result", rsp_result, WIDTH'(12));
    check("add_tag", WIDTH'(rsp_tag), WIDTH'(3));
    check("add_err", WIDTH'(rsp_err), WIDTH'(0));
    check("add_flags", WIDTH'(rsp_flags), WIDTH'(4'b0000));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("add_popped", WIDTH'(rsp_valid), WIDTH'(0));
    check("add_outstanding_0", WIDTH'(dut.outstanding), WIDTH'(0));

    // SUB 0 - 1: all ones, borrow and sign set -> flags {1,0,0,1}
    set_req(4'd1, WIDTH'(0), WIDTH'(1), 5'd0, 4'd5);
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    check("sub_result", rsp_result, {WIDTH{1'b1}});
    check("sub_flags", WIDTH'(rsp_flags), WIDTH'(4'b1001));
    check("sub_tag", WIDTH'(rsp_tag), WIDTH'(5));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // illegal opcode 9: forwarded, ALU default 0, zero flag only, err set
    set_req(4'd9, WIDTH'(8'hff), WIDTH'(1), 5'd0, 4'ha);
    tick();
    req_valid = 1'b0;
    check("ill_alu_opcode", WIDTH'(alu_opcode), WIDTH'(9));
    repeat (3) tick();
    check("ill_valid", WIDTH'(rsp_valid), WIDTH'(1));
    check("ill_err", WIDTH'(rsp_err), WIDTH'(1));
    check("ill_tag", WIDTH'(rsp_tag), WIDTH'(4'ha));
    check("ill_result", rsp_result, WIDTH'(0));
    check("ill_flags", WIDTH'(rsp_flags), WIDTH'(4'b0100));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // streaming: 8 ADDs (100+k) + k, tags 0..7, rsp_ready held high
    rsp_ready = 1'b1;
    k = 0;
    got = 0;
    cyc = 0;
    stall = 1'b0;
    while ((k < 8 || got < 8) && cyc < 200) begin
      if (k < 8) set_req(4'd0, WIDTH'(100 + k), WIDTH'(k), 5'd0, 4'(k));
      else req_valid = 1'b0;
      if (rsp_valid) begin
        score_head("stream");
        got++;
      end
      if (req_valid && req_ready) begin
        exp_q.push_back({1'b0, 4'(k), WIDTH'(100 + 2 * k)});
        k++;
      end else if (req_valid) begin
        stall = 1'b1;
      end
      tick();
      cyc++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("stream_fired", WIDTH'(k), WIDTH'(8));
    check("stream_got", WIDTH'(got), WIDTH'(8));
    check("stream_stalled", WIDTH'(stall), WIDTH'(1));
    check("stream_queue_empty", WIDTH'(exp_q.size()), WIDTH'(0));
    check("stream_outstanding", WIDTH'(dut.outstanding), WIDTH'(0));

    // backpressure: offer 5 requests (16*t + 1) with rsp_ready low; only 4 accepted
    nxt = 1;
    repeat (8) begin
      set_req(4'd0, WIDTH'(16 * nxt), WIDTH'(1), 5'd0, 4'(nxt));
      if (req_ready) begin
        exp_q.push_back({1'b0, 4'(nxt), WIDTH'(16 * nxt + 1)});
        nxt++;
      end
      tick();
    end
    check("bp_accepted", WIDTH'(nxt - 1), WIDTH'(4));
    check("bp_req_ready", WIDTH'(req_ready), WIDTH'(0));
    check("bp_outstanding", WIDTH'(dut.outstanding), WIDTH'(4));
    check("bp_rsp_valid", WIDTH'(rsp_valid), WIDTH'(1));
    repeat (2) tick();
    check("bp_stable_tag", WIDTH'(rsp_tag), WIDTH'(1));
    check("bp_stable_result", rsp_result, WIDTH'(17));

    // one pop frees exactly one slot
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    score_head("bp_pop");
    tick();
    rsp_ready = 1'b0;
    check("bp_ready_after_pop", WIDTH'(req_ready), WIDTH'(1));
    check("bp_outstanding_3", WIDTH'(dut.outstanding), WIDTH'(3));

    // simultaneous fire and pop at DEPTH-1: 96 + 1 = 97, tag 6
    set_req(4'd0, WIDTH'(96), WIDTH'(1), 5'd0, 4'd6);
    rsp_ready = 1'b1;
    score_head("fp_pop");
    exp_q.push_back({1'b0, 4'd6, WIDTH'(97)});
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("fp_outstanding", WIDTH'(dut.outstanding), WIDTH'(3));
    check("fp_head_tag", WIDTH'(rsp_tag), WIDTH'(3));
    drain(3);
    check("fp_outstanding_0", WIDTH'(dut.outstanding), WIDTH'(0));

    // reset with 3 ops in flight discards everything
    set_req(4'd0, WIDTH'(1), WIDTH'(1), 5'd0, 4'd7);
    tick();
    set_req(4'd0, WIDTH'(2), WIDTH'(2), 5'd0, 4'd8);
    tick();
    set_req(4'd0, WIDTH'(3), WIDTH'(3), 5'd0, 4'd9);
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    any_valid = 1'b0;
    repeat (6) begin
      if (rsp_valid) any_valid = 1'b1;
      tick();
    end
    check("mid_rst_no_rsp", WIDTH'(any_valid), WIDTH'(0));
    check("mid_rst_outstanding", WIDTH'(dut.outstanding), WIDTH'(0));
    check("mid_rst_req_ready", WIDTH'(req_ready), WIDTH'(1));
    check("mid_rst_alu_input1", alu_input1, WIDTH'(0));
    check("mid_rst_rsp_result", rsp_result, WIDTH'(0));
    check("mid_rst_rsp_tag", WIDTH'(rsp_tag), WIDTH'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
